// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write arbiter: register file geometry,
// default requester count and the fixed requester index assignments.
package rf_arb_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  localparam int RF_NREQ = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_NOC  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-wide round-robin arbiter: one-hot grant to the first valid requester
// at or after ptr (wrap order); ptr moves past the winner on each accepted grant.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  valid,
  input  logic          accept_en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;

  // NOTE: every variable written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!any_grant && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept_en && any_grant) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin share of the register file's single write port among NREQ sources.
// Define RF_WRITE_ARB_SCOREBOARD_EN to build the outstanding-write busy bitmap.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wa,
  output logic [DW-1:0]      rf_wd,
  output logic [IW-1:0]      grant_id,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_addr,
  output logic [2**AW-1:0]   busy
);

  logic [IW-1:0] gidx;
  logic          accepted;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // The write port never backpressures, so every grant is accepted.
  rr_arbiter #(.N(NREQ), .PW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .accept_en (1'b1),
    .grant     (req_ready),
    .grant_idx (gidx),
    .any_grant (accepted)
  );

  assign sel_addr = req_addr[int'(gidx)*AW +: AW];
  assign sel_data = req_data[int'(gidx)*DW +: DW];

  // Writes to x0 are accepted (ptr advances) but never strobe the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      grant_id <= '0;
    end else if (accepted) begin
      rf_we    <= (sel_addr != '0);
      rf_wa    <= sel_addr;
      rf_wd    <= sel_data;
      grant_id <= gidx;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef RF_WRITE_ARB_SCOREBOARD_EN
  logic [2**AW-1:0] busy_q;
  logic [2**AW-1:0] busy_set;
  logic [2**AW-1:0] busy_clr;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (rsv_valid && rsv_addr != '0) busy_set[rsv_addr] = 1'b1;
    if (rf_we)                       busy_clr[rf_wa]    = 1'b1;
  end

  // Set is applied after clear so a same-edge reservation wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~busy_clr) | busy_set;
  end

  assign busy = busy_q;
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_addr};
  assign busy       = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (NREQ=3); the scoreboard
// section follows RF_WRITE_ARB_SCOREBOARD_EN.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_we;
  logic [AW-1:0]      rf_wa;
  logic [DW-1:0]      rf_wd;
  logic [1:0]         grant_id;
  logic               rsv_valid;
  logic [AW-1:0]      rsv_addr;
  logic [31:0]        busy;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .grant_id  (grant_id),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_gid;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    step();
    check("reset rf_we",    64'(rf_we),    64'd0);
    check("reset rf_wa",    64'(rf_wa),    64'd0);
    check("reset rf_wd",    64'(rf_wd),    64'd0);
    check("reset grant_id", 64'(grant_id), 64'd0);
    check("reset busy",     64'(busy),     64'd0);
    check("idle ready",     64'(req_ready), 64'd0);
    #2 rst = 1'b0;

    // Single write from requester 0.
    step();
    set_req(REQ_ALU, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    #1 check("single ready", 64'(req_ready), 64'b001);
    step();
    req_valid = '0;
    check("single rf_we",    64'(rf_we),    64'd1);
    check("single rf_wa",    64'(rf_wa),    64'd5);
    check("single rf_wd",    64'(rf_wd),    64'hDEAD_BEEF);
    check("single grant_id", 64'(grant_id), 64'd0);
    step();
    check("single we drop", 64'(rf_we), 64'd0);
    check("single wa hold", 64'(rf_wa), 64'd5);

    // x0 write from requester 1 (ptr is 1): accepted, no strobe.
    set_req(REQ_LOAD, 5'd0, 32'h0000_1234);
    req_valid = 3'b010;
    #1 check("x0 ready", 64'(req_ready), 64'b010);
    step();
    req_valid = '0;
    check("x0 rf_we",    64'(rf_we),    64'd0);
    check("x0 rf_wa",    64'(rf_wa),    64'd0);
    check("x0 rf_wd",    64'(rf_wd),    64'h1234);
    check("x0 grant_id", 64'(grant_id), 64'd1);

    // All valid: ptr must now be 2.
    set_req(REQ_ALU,  5'd10, 32'hA0A0_0000);
    set_req(REQ_LOAD, 5'd11, 32'hB1B1_1111);
    set_req(REQ_NOC,  5'd12, 32'hC2C2_2222);
    req_valid = 3'b111;
    #1 check("ptr after x0", 64'(req_ready), 64'b100);
    exp_gid = 2'd2;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("rr1 gid c%0d", c), 64'(grant_id), 64'(exp_gid));
      check($sformatf("rr1 we c%0d", c),  64'(rf_we),    64'd1);
      check($sformatf("rr1 wa c%0d", c),  64'(rf_wa),    64'(10 + exp_gid));
      exp_gid = (exp_gid == 2'd2) ? 2'd0 : exp_gid + 2'd1;
    end

    // Mid-stream asynchronous reset.
    #2 rst = 1'b1;
    #1;
    check("midrst rf_we",    64'(rf_we),    64'd0);
    check("midrst grant_id", 64'(grant_id), 64'd0);
    check("midrst rf_wa",    64'(rf_wa),    64'd0);
    check("midrst busy",     64'(busy),     64'd0);
    step();
    #2 rst = 1'b0;
    #1 check("post-rst ready", 64'(req_ready), 64'b001);

    // Round-robin from ptr=0: 0,1,2,0,1,2 back to back.
    exp_gid = 2'd0;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("rr2 gid c%0d", c), 64'(grant_id), 64'(exp_gid));
      check($sformatf("rr2 we c%0d", c),  64'(rf_we),    64'd1);
      check($sformatf("rr2 wd c%0d", c),  64'(rf_wd),    64'(req_data[exp_gid*DW +: DW]));
      exp_gid = (exp_gid == 2'd2) ? 2'd0 : exp_gid + 2'd1;
    end
    req_valid = '0;
    step();
    check("idle we", 64'(rf_we), 64'd0);

`ifdef RF_WRITE_ARB_SCOREBOARD_EN
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    step();
    rsv_valid = 1'b0;
    check("sb set 7", 64'(busy), 64'h80);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd0;
    step();
    rsv_valid = 1'b0;
    check("sb x0 ignored", 64'(busy), 64'h80);
    set_req(REQ_NOC, 5'd7, 32'h7777_7777);
    req_valid = 3'b100;
    step();
    req_valid = '0;
    check("sb wr we",    64'(rf_we), 64'd1);
    check("sb hold 7",   64'(busy),  64'h80);
    step();
    check("sb clear 7",  64'(busy),  64'h0);
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    step();
    rsv_valid = 1'b0;
    req_valid = 3'b100;
    step();
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    check("sb race we", 64'(rf_we), 64'd1);
    step();
    rsv_valid = 1'b0;
    check("sb set wins", 64'(busy), 64'h80);
    step();
    check("sb stays", 64'(busy), 64'h80);
`else
    for (int a = 1; a < 32; a++) begin
      rsv_valid = 1'b1;
      rsv_addr  = AW'(a);
      step();
      check($sformatf("sb off a%0d", a), 64'(busy), 64'd0);
    end
    rsv_valid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
